beta_trap_csr_file: RTL and testbench

- Machine-mode trap CSR register file, directly downstream of the trap control unit.
- On a trap, latches the unit's mepc/mcause/mtval/trap-state/pending outputs.
- Services Zicsr read/write/set/clear accesses and executes MRET.
- Feeds csr_ctrl_t (mie, mtvec, interrupt pending/enable pairs) and the privilege level back to the trap control unit; also holds mcycle/minstret.

---
 rtl/beta_csr_pkg.sv | 59 +++++
 rtl/beta_csr_counter64.sv | 25 ++
 rtl/beta_trap_csr_file.sv | 184 ++++++++++++++++++
 tb/tb_beta_trap_csr_file.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_csr_pkg.sv
// beta_csr_pkg: shared CSR addresses, op encoding, bit positions and the trap-unit control bundle
package beta_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Same positions are used by mie and mip.
    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_t;

    // Interrupt pairs are {enable, pending}.
    typedef struct packed {
        logic        mie;
        logic [31:0] mtvec;
        logic [1:0]  soft_int;
        logic [1:0]  tim_int;
        logic [1:0]  ext_int;
    } csr_ctrl_t;

    // Compact {EXT, TIM, SW} triple <-> architectural mie/mip word.
    function automatic logic [31:0] irq_word(input logic [2:0] b);
        irq_word = '0;
        irq_word[MIP_MSIP] = b[0];
        irq_word[MIP_MTIP] = b[1];
        irq_word[MIP_MEIP] = b[2];
    endfunction

    function automatic logic [2:0] irq_bits(input logic [31:0] w);
        return {w[MIP_MEIP], w[MIP_MTIP], w[MIP_MSIP]};
    endfunction

endpackage

// File: rtl/beta_csr_counter64.sv
// beta_csr_counter64: 64-bit counter with increment enable and per-half write strobes
// Ports: clk_i/rst_i clock and sync reset; inc_i count enable; wr_lo_i/wr_hi_i replace a half
// with wdata_i (and suppress that cycle's increment); count_o current value.
module beta_csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_o[31:0] <= wdata_i;
            if (wr_hi_i) count_o[63:32] <= wdata_i;
        end else if (inc_i) begin
            count_o <= count_o + 64'd1;
        end
    end

endmodule

// File: rtl/beta_trap_csr_file.sv
// beta_trap_csr_file: machine-mode trap CSR file with Zicsr access, trap capture, MRET and counters
// Ports: csr_* Zicsr access (combinational rdata/illegal, update at next edge);
// trap_* trap commit values and pending-set requests; mret_i MRET commit;
// instr_retired_i minstret increment; csr_ctrl_o/priv_lvl_o/mepc_o feedback to the trap unit.
module beta_trap_csr_file
    import beta_csr_pkg::*;
#(
    parameter int                   DataWidth      = 32,
    parameter logic [DataWidth-1:0] BootTrapVector = '0,
    parameter int                   HartId         = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 csr_en_i,
    input  logic [1:0]           csr_op_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [DataWidth-1:0] csr_wdata_i,
    output logic [DataWidth-1:0] csr_rdata_o,
    output logic                 csr_illegal_o,
    input  logic                 trap_we_i,
    input  logic [DataWidth-1:0] trap_mepc_i,
    input  logic [DataWidth-1:0] trap_mcause_i,
    input  logic [DataWidth-1:0] trap_mtval_i,
    input  logic [2:0]           trap_state_i,
    input  logic                 trap_sw_pend_i,
    input  logic                 trap_tim_pend_i,
    input  logic                 trap_ext_pend_i,
    input  logic                 mret_i,
    input  logic                 instr_retired_i,
    output csr_ctrl_t            csr_ctrl_o,
    output logic                 priv_lvl_o,
    output logic [DataWidth-1:0] mepc_o
);

    csr_op_t              op;
    logic [DataWidth-1:0] rdata, wnew, mstatus_val;
    logic [DataWidth-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic                 mie_q, mpie_q, priv_q;
    logic [1:0]           mpp_q;
    logic [2:0]           irq_en_q, irq_pend_q, pend_set;
    logic                 mapped, read_only, csr_wr;
    logic                 wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
    logic                 wr_mcause, wr_mtval, wr_mip;
    logic                 wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
    logic [63:0]          mcycle, minstret;

    assign op = csr_op_t'(csr_op_i);

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE] = mie_q;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
    end

    always_comb begin
        rdata = '0;
        mapped = 1'b1;
        read_only = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:   rdata = mstatus_val;
            CSR_MISA: begin
                rdata = MISA_VALUE;
                read_only = 1'b1;
            end
            CSR_MIE:       rdata = irq_word(irq_en_q);
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = irq_word(irq_pend_q);
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MHARTID: begin
                rdata = DataWidth'(HartId);
                read_only = 1'b1;
            end
            default:       mapped = 1'b0;
        endcase
    end

    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = csr_en_i && (!mapped || (op != CSR_READ && read_only));
    assign csr_wr        = csr_en_i && op != CSR_READ && !csr_illegal_o;
    assign wnew          = op == CSR_WRITE ? csr_wdata_i :
                           op == CSR_SET   ? rdata | csr_wdata_i : rdata & ~csr_wdata_i;

    assign wr_mstatus   = csr_wr && csr_addr_i == CSR_MSTATUS;
    assign wr_mie       = csr_wr && csr_addr_i == CSR_MIE;
    assign wr_mtvec     = csr_wr && csr_addr_i == CSR_MTVEC;
    assign wr_mscratch  = csr_wr && csr_addr_i == CSR_MSCRATCH;
    assign wr_mepc      = csr_wr && csr_addr_i == CSR_MEPC;
    assign wr_mcause    = csr_wr && csr_addr_i == CSR_MCAUSE;
    assign wr_mtval     = csr_wr && csr_addr_i == CSR_MTVAL;
    assign wr_mip       = csr_wr && csr_addr_i == CSR_MIP;
    assign wr_mcycle    = csr_wr && csr_addr_i == CSR_MCYCLE;
    assign wr_mcycleh   = csr_wr && csr_addr_i == CSR_MCYCLEH;
    assign wr_minstret  = csr_wr && csr_addr_i == CSR_MINSTRET;
    assign wr_minstreth = csr_wr && csr_addr_i == CSR_MINSTRETH;

    assign pend_set = {trap_ext_pend_i, trap_tim_pend_i, trap_sw_pend_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= 2'b11;
            priv_q     <= 1'b1;
            mtvec_q    <= BootTrapVector;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            irq_en_q   <= '0;
            irq_pend_q <= '0;
        end else begin
            // Trap, MRET and a CSR write all touch every mstatus field, so the
            // highest-priority event among them owns the whole register.
            if (trap_we_i) begin
                mie_q  <= trap_state_i[2];
                mpie_q <= trap_state_i[1];
                mpp_q  <= {2{trap_state_i[0]}};
                priv_q <= 1'b1;
            end else if (mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
                mpp_q  <= 2'b00;
                priv_q <= mpp_q == 2'b11;
            end else if (wr_mstatus) begin
                mie_q  <= wnew[MSTATUS_MIE];
                mpie_q <= wnew[MSTATUS_MPIE];
                mpp_q  <= wnew[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b11 ? 2'b11 : 2'b00;
            end
            if (trap_we_i) begin
                mepc_q   <= trap_mepc_i & ~DataWidth'(3);
                mcause_q <= trap_mcause_i;
                mtval_q  <= trap_mtval_i;
            end else begin
                if (wr_mepc) mepc_q <= wnew & ~DataWidth'(3);
                if (wr_mcause) mcause_q <= wnew;
                if (wr_mtval) mtval_q <= wnew;
            end
            if (wr_mtvec) mtvec_q <= wnew & ~DataWidth'(2);
            if (wr_mscratch) mscratch_q <= wnew;
            if (wr_mie) irq_en_q <= irq_bits(wnew);
            // Hardware set requests are OR-ed last so they beat a same-cycle clear.
            irq_pend_q <= (wr_mip ? irq_bits(wnew) : irq_pend_q) | pend_set;
        end
    end

    beta_csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (wr_mcycle),
        .wr_hi_i (wr_mcycleh),
        .wdata_i (wnew),
        .count_o (mcycle)
    );

    beta_csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instr_retired_i),
        .wr_lo_i (wr_minstret),
        .wr_hi_i (wr_minstreth),
        .wdata_i (wnew),
        .count_o (minstret)
    );

    assign csr_ctrl_o = '{
        mie:      mie_q,
        mtvec:    mtvec_q,
        soft_int: {irq_en_q[0], irq_pend_q[0]},
        tim_int:  {irq_en_q[1], irq_pend_q[1]},
        ext_int:  {irq_en_q[2], irq_pend_q[2]}
    };
    assign priv_lvl_o = priv_q;
    assign mepc_o     = mepc_q;

endmodule

// File: tb/tb_beta_trap_csr_file.sv
// tb_beta_trap_csr_file: directed and randomized checks of beta_trap_csr_file against a word-level model
module tb_beta_trap_csr_file;
    import beta_csr_pkg::*;

    localparam logic [31:0] BOOT = 32'h1000_0040;
    localparam int          HART = 5;

    logic        clk = 1'b0;
    logic        rst_i, csr_en_i, csr_illegal_o, trap_we_i, mret_i, instr_retired_i;
    logic        trap_sw_pend_i, trap_tim_pend_i, trap_ext_pend_i, priv_lvl_o;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, csr_rdata_o, trap_mepc_i, trap_mcause_i, trap_mtval_i, mepc_o;
    logic [2:0]  trap_state_i;
    csr_ctrl_t   csr_ctrl_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_mstatus, m_mtvec, m_mie, m_mip, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;
    logic        m_priv;

    always #5 clk = ~clk;

    beta_trap_csr_file #(
        .DataWidth      (32),
        .BootTrapVector (BOOT),
        .HartId         (HART)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .csr_en_i        (csr_en_i),
        .csr_op_i        (csr_op_i),
        .csr_addr_i      (csr_addr_i),
        .csr_wdata_i     (csr_wdata_i),
        .csr_rdata_o     (csr_rdata_o),
        .csr_illegal_o   (csr_illegal_o),
        .trap_we_i       (trap_we_i),
        .trap_mepc_i     (trap_mepc_i),
        .trap_mcause_i   (trap_mcause_i),
        .trap_mtval_i    (trap_mtval_i),
        .trap_state_i    (trap_state_i),
        .trap_sw_pend_i  (trap_sw_pend_i),
        .trap_tim_pend_i (trap_tim_pend_i),
        .trap_ext_pend_i (trap_ext_pend_i),
        .mret_i          (mret_i),
        .instr_retired_i (instr_retired_i),
        .csr_ctrl_o      (csr_ctrl_o),
        .priv_lvl_o      (priv_lvl_o),
        .mepc_o          (mepc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void mread(input logic [11:0] a, output logic [31:0] v, output bit ok, output bit ro);
        ok = 1'b1;
        ro = 1'b0;
        v = '0;
        case (a)
            12'h300: v = m_mstatus;
            12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_mip;
            12'hB00: v = m_mcycle[31:0];
            12'hB80: v = m_mcycle[63:32];
            12'hB02: v = m_minstret[31:0];
            12'hB82: v = m_minstret[63:32];
            12'hF14: begin v = 32'(HART); ro = 1'b1; end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h0000_1800;
        m_priv = 1'b1;
        m_mtvec = BOOT;
        {m_mie, m_mip, m_mscratch, m_mepc, m_mcause, m_mtval} = '0;
        m_mcycle = '0;
        m_minstret = '0;
    endtask

    // Lowest-priority effects are applied first and later events overwrite them.
    task automatic model_update();
        logic [31:0] old, nv, n_mstatus, n_mtvec, n_mie, n_mip, n_mscratch, n_mepc, n_mcause, n_mtval;
        logic [63:0] n_cyc, n_ins;
        logic        n_priv;
        bit          ok, ro, wr;
        if (rst_i) begin
            model_reset();
            return;
        end
        mread(csr_addr_i, old, ok, ro);
        wr = csr_en_i && csr_op_i != 2'b00 && ok && !ro;
        nv = csr_op_i == 2'b01 ? csr_wdata_i : csr_op_i == 2'b10 ? old | csr_wdata_i : old & ~csr_wdata_i;
        {n_mstatus, n_mtvec, n_mie, n_mip} = {m_mstatus, m_mtvec, m_mie, m_mip};
        {n_mscratch, n_mepc, n_mcause, n_mtval} = {m_mscratch, m_mepc, m_mcause, m_mtval};
        n_priv = m_priv;
        n_cyc = m_mcycle + 64'd1;
        n_ins = m_minstret + (instr_retired_i ? 64'd1 : 64'd0);
        if (wr) begin
            case (csr_addr_i)
                12'h300: n_mstatus = nv & (nv[12:11] == 2'b11 ? 32'h1888 : 32'h0088);
                12'h304: n_mie = nv & 32'h888;
                12'h305: n_mtvec = nv & ~32'h2;
                12'h340: n_mscratch = nv;
                12'h341: n_mepc = nv & ~32'h3;
                12'h342: n_mcause = nv;
                12'h343: n_mtval = nv;
                12'h344: n_mip = nv & 32'h888;
                12'hB00: n_cyc = {m_mcycle[63:32], nv};
                12'hB80: n_cyc = {nv, m_mcycle[31:0]};
                12'hB02: n_ins = {m_minstret[63:32], nv};
                12'hB82: n_ins = {nv, m_minstret[31:0]};
                default: ;
            endcase
        end
        if (mret_i) begin
            n_mstatus = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
            n_priv = m_mstatus[12:11] == 2'b11;
        end
        if (trap_we_i) begin
            n_mstatus = (trap_state_i[2] ? 32'h8 : 32'h0) | (trap_state_i[1] ? 32'h80 : 32'h0) |
                        (trap_state_i[0] ? 32'h1800 : 32'h0);
            n_priv = 1'b1;
            n_mepc = trap_mepc_i & ~32'h3;
            n_mcause = trap_mcause_i;
            n_mtval = trap_mtval_i;
        end
        n_mip |= (trap_sw_pend_i ? 32'h8 : 32'h0) | (trap_tim_pend_i ? 32'h80 : 32'h0) |
                 (trap_ext_pend_i ? 32'h800 : 32'h0);
        {m_mstatus, m_mtvec, m_mie, m_mip} = {n_mstatus, n_mtvec, n_mie, n_mip};
        {m_mscratch, m_mepc, m_mcause, m_mtval} = {n_mscratch, n_mepc, n_mcause, n_mtval};
        m_priv = n_priv;
        m_mcycle = n_cyc;
        m_minstret = n_ins;
    endtask

    task automatic idle();
        {csr_en_i, trap_we_i, mret_i, instr_retired_i} = '0;
        {trap_sw_pend_i, trap_tim_pend_i, trap_ext_pend_i} = '0;
        csr_op_i = 2'b00;
    endtask

    task automatic drive(input logic en, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        csr_en_i = en;
        csr_op_i = op;
        csr_addr_i = a;
        csr_wdata_i = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_comb();
        logic [31:0] v;
        bit          ok, ro;
        mread(csr_addr_i, v, ok, ro);
        chk("illegal", 64'(csr_illegal_o), 64'(csr_en_i && (!ok || (csr_op_i != 2'b00 && ro))));
        if (ok) chk($sformatf("rdata_%h", csr_addr_i), 64'(csr_rdata_o), 64'(v));
    endtask

    task automatic check_state();
        csr_ctrl_t e;
        e.mie = m_mstatus[3];
        e.mtvec = m_mtvec;
        e.soft_int = {m_mie[3], m_mip[3]};
        e.tim_int = {m_mie[7], m_mip[7]};
        e.ext_int = {m_mie[11], m_mip[11]};
        chk("csr_ctrl", 64'(csr_ctrl_o), 64'(e));
        chk("priv", 64'(priv_lvl_o), 64'(m_priv));
        chk("mepc_o", 64'(mepc_o), 64'(m_mepc));
    endtask

    task automatic cyc();
        check_comb();
        tick();
        check_state();
        idle();
    endtask

    initial begin
        logic [11:0] tab [16];
        tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h302};
        idle();
        {csr_addr_i, csr_wdata_i, trap_mepc_i, trap_mcause_i, trap_mtval_i} = '0;
        trap_state_i = '0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        drive(1, 2'b00, 12'h300, 0);
        chk("rst_mstatus", 64'(csr_rdata_o), 64'('h1800));
        chk("rst_priv", 64'(priv_lvl_o), 64'(1));
        cyc();
        drive(1, 2'b00, 12'h305, 0);
        chk("rst_mtvec", 64'(csr_rdata_o), 64'(BOOT));
        cyc();

        drive(1, 2'b01, 12'h305, 32'h8000_0003);
        cyc();
        drive(1, 2'b00, 12'h305, 0);
        chk("mtvec_bit1", 64'(csr_rdata_o), 64'('h8000_0001));
        cyc();

        drive(1, 2'b10, 12'h304, 32'h888);
        cyc();
        chk("mie_enables", 64'({csr_ctrl_o.ext_int[1], csr_ctrl_o.tim_int[1], csr_ctrl_o.soft_int[1]}), 64'(3'b111));

        trap_we_i = 1'b1;
        trap_mepc_i = 32'h100;
        trap_mcause_i = 32'h8000_000B;
        trap_mtval_i = 32'h0;
        trap_state_i = 3'b011;
        drive(0, 2'b00, 12'h300, 0);
        cyc();
        drive(1, 2'b00, 12'h300, 0);
        chk("trap_mstatus", 64'(csr_rdata_o), 64'('h1880));
        chk("trap_mepc", 64'(mepc_o), 64'('h100));
        cyc();

        mret_i = 1'b1;
        drive(0, 2'b00, 12'h300, 0);
        cyc();
        drive(1, 2'b00, 12'h300, 0);
        chk("mret_mstatus", 64'(csr_rdata_o), 64'('h0088));
        chk("mret_priv_m", 64'(priv_lvl_o), 64'(1));
        cyc();

        drive(1, 2'b11, 12'h300, 32'h1800);
        cyc();
        mret_i = 1'b1;
        drive(0, 2'b00, 12'h300, 0);
        cyc();
        chk("mret_priv_u", 64'(priv_lvl_o), 64'(0));

        trap_we_i = 1'b1;
        trap_mepc_i = 32'h300;
        trap_state_i = 3'b011;
        drive(1, 2'b01, 12'h341, 32'h200);
        cyc();
        chk("trap_beats_csr_mepc", 64'(mepc_o), 64'('h300));

        trap_tim_pend_i = 1'b1;
        drive(1, 2'b11, 12'h344, 32'h80);
        cyc();
        drive(1, 2'b00, 12'h344, 0);
        chk("pend_beats_clear", 64'(csr_rdata_o & 32'h80), 64'('h80));
        cyc();

        drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
        cyc();
        drive(1, 2'b01, 12'hB80, 32'hFFFF_FFFF);
        cyc();
        drive(1, 2'b00, 12'hB80, 0);
        chk("mcycleh_max", 64'(csr_rdata_o), 64'('hFFFF_FFFF));
        cyc();
        drive(1, 2'b00, 12'hB00, 0);
        chk("mcycle_wrap_lo", 64'(csr_rdata_o), 64'(0));
        cyc();
        drive(1, 2'b00, 12'hB80, 0);
        chk("mcycle_wrap_hi", 64'(csr_rdata_o), 64'(0));
        cyc();

        drive(1, 2'b01, 12'h301, 32'h0);
        chk("misa_wr_illegal", 64'(csr_illegal_o), 64'(1));
        cyc();
        drive(1, 2'b00, 12'h301, 0);
        chk("misa_value", 64'(csr_rdata_o), 64'('h4000_0100));
        chk("misa_rd_legal", 64'(csr_illegal_o), 64'(0));
        cyc();
        drive(1, 2'b00, 12'hF14, 0);
        chk("mhartid", 64'(csr_rdata_o), 64'(HART));
        cyc();

        drive(1, 2'b00, 12'h7C0, 0);
        chk("unmapped_illegal", 64'(csr_illegal_o), 64'(1));
        cyc();
        drive(0, 2'b00, 12'h7C0, 0);
        chk("illegal_gated", 64'(csr_illegal_o), 64'(0));
        cyc();

        rst_i = 1'b1;
        trap_we_i = 1'b1;
        trap_mepc_i = 32'h444;
        trap_state_i = 3'b111;
        mret_i = 1'b1;
        trap_sw_pend_i = 1'b1;
        drive(1, 2'b01, 12'h340, 32'hDEAD);
        cyc();
        rst_i = 1'b0;
        drive(1, 2'b00, 12'h300, 0);
        chk("midrst_mstatus", 64'(csr_rdata_o), 64'('h1800));
        chk("midrst_mepc", 64'(mepc_o), 64'(0));
        cyc();
        drive(1, 2'b00, 12'h344, 0);
        chk("midrst_mip", 64'(csr_rdata_o), 64'(0));
        cyc();

        for (int i = 0; i < 800; i++) begin
            rst_i = $urandom_range(0, 199) == 0;
            trap_we_i = $urandom_range(0, 7) == 0;
            mret_i = $urandom_range(0, 7) == 0;
            trap_mepc_i = $urandom;
            trap_mcause_i = $urandom;
            trap_mtval_i = $urandom;
            trap_state_i = 3'($urandom);
            trap_sw_pend_i = $urandom_range(0, 5) == 0;
            trap_tim_pend_i = $urandom_range(0, 5) == 0;
            trap_ext_pend_i = $urandom_range(0, 5) == 0;
            instr_retired_i = 1'($urandom);
            drive($urandom_range(0, 3) != 0, 2'($urandom), tab[$urandom_range(0, 15)],
                  $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
            cyc();
        end
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
